// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures the decode bundle, inserts bubbles on
// load-use hazards and flushes, holds on EX stall, and counts bubbles.
module id_ex_reg #(
  parameter int DW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_ex,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_pc,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic [4:0]    id_dst,
  input  logic [DW-1:0] id_rd1,
  input  logic [DW-1:0] id_rd2,
  input  logic [DW-1:0] id_imm,
  input  logic [3:0]    id_alu_op,
  input  logic          id_reg_we,
  input  logic          id_mem_rd,
  input  logic          id_mem_wr,
  output logic          ex_valid,
  output logic          ex_reg_we,
  output logic          ex_mem_rd,
  output logic          ex_mem_wr,
  output logic [DW-1:0] ex_pc,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_imm,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_dst,
  output logic [3:0]    ex_alu_op,
  output logic          id_stall,
  output logic [CW-1:0] lu_cnt,
  output logic [CW-1:0] fl_cnt
);

  logic lu;

  // Saturating increment: a counter parked at all-ones stays there.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c);
    return (&c) ? c : c + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  // Register 0 is hardwired, so a load targeting it never creates a hazard.
  assign lu = ex_valid & ex_mem_rd & (ex_dst != 5'd0) & id_valid &
              ((id_uses_rs & (ex_dst == id_rs)) | (id_uses_rt & (ex_dst == id_rt)));

  assign id_stall = stall_ex | lu;

  // ID -> EX boundary
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid  <= 1'b0;
      ex_reg_we <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;
      ex_pc     <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_dst    <= '0;
      ex_alu_op <= '0;
      lu_cnt    <= '0;
      fl_cnt    <= '0;
    end else if (stall_ex) begin
      // hold everything, counters included
    end else if (flush || lu) begin
      ex_valid  <= 1'b0;
      ex_reg_we <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;
      ex_pc     <= '0;
      ex_a      <= '0;
      ex_b      <= '0;
      ex_imm    <= '0;
      ex_rs     <= '0;
      ex_rt     <= '0;
      ex_dst    <= '0;
      ex_alu_op <= '0;
      // A flush takes credit for the bubble even when a hazard coincides.
      if (flush) fl_cnt <= sat_inc(fl_cnt);
      else       lu_cnt <= sat_inc(lu_cnt);
    end else begin
      ex_valid  <= id_valid;
      ex_reg_we <= id_valid & id_reg_we;
      ex_mem_rd <= id_valid & id_mem_rd;
      ex_mem_wr <= id_valid & id_mem_wr;
      ex_pc     <= id_pc;
      ex_a      <= id_rd1;
      ex_b      <= id_rd2;
      ex_imm    <= id_imm;
      ex_rs     <= id_rs;
      ex_rt     <= id_rt;
      ex_dst    <= id_dst;
      ex_alu_op <= id_alu_op;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: vector table for the cycle-by-cycle flow plus
// hand sequences for reset-during-stall and counter saturation (CW=2).
module tb_id_ex_reg;
  logic        clk = 1'b0;
  logic        rst, stall_ex, flush;
  logic        id_valid, id_uses_rs, id_uses_rt, id_reg_we, id_mem_rd, id_mem_wr;
  logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
  logic [4:0]  id_rs, id_rt, id_dst;
  logic [3:0]  id_alu_op;
  logic        ex_valid, ex_reg_we, ex_mem_rd, ex_mem_wr, id_stall;
  logic [31:0] ex_pc, ex_a, ex_b, ex_imm;
  logic [4:0]  ex_rs, ex_rt, ex_dst;
  logic [3:0]  ex_alu_op;
  logic [1:0]  lu_cnt, fl_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_ex_reg #(.DW(32), .CW(2)) dut (
    .clk(clk), .rst(rst), .stall_ex(stall_ex), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dst(id_dst),
    .id_rd1(id_rd1), .id_rd2(id_rd2), .id_imm(id_imm), .id_alu_op(id_alu_op),
    .id_reg_we(id_reg_we), .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr),
    .ex_valid(ex_valid), .ex_reg_we(ex_reg_we), .ex_mem_rd(ex_mem_rd),
    .ex_mem_wr(ex_mem_wr), .ex_pc(ex_pc), .ex_a(ex_a), .ex_b(ex_b),
    .ex_imm(ex_imm), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
    .ex_alu_op(ex_alu_op), .id_stall(id_stall), .lu_cnt(lu_cnt), .fl_cnt(fl_cnt)
  );

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [4:0]  rs, rt;
    logic        urs, urt;
    logic [4:0]  dst;
    logic [31:0] a, b, imm;
    logic [3:0]  op;
    logic        we, mr, mw;
  } ins_t;

  typedef struct {
    logic       sx, fl;
    ins_t       in;
    logic       e_st;
    ins_t       out;
    logic [1:0] e_lu, e_fl;
  } vec_t;

  vec_t vecs[$];

  function automatic ins_t mk(int v, logic [31:0] pc, int rs, int rt, int urs, int urt,
                              int dst, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                              int op, int we, int mr, int mw);
    ins_t r;
    r.v = v[0]; r.pc = pc; r.rs = rs[4:0]; r.rt = rt[4:0];
    r.urs = urs[0]; r.urt = urt[0]; r.dst = dst[4:0];
    r.a = a; r.b = b; r.imm = imm; r.op = op[3:0];
    r.we = we[0]; r.mr = mr[0]; r.mw = mw[0];
    return r;
  endfunction

  task automatic add(input logic sx, input logic fl, input ins_t in, input logic st,
                     input ins_t out, input logic [1:0] lu, input logic [1:0] fc);
    vec_t t;
    t.sx = sx; t.fl = fl; t.in = in; t.e_st = st; t.out = out; t.e_lu = lu; t.e_fl = fc;
    vecs.push_back(t);
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input ins_t i);
    id_valid = i.v; id_pc = i.pc; id_rs = i.rs; id_rt = i.rt;
    id_uses_rs = i.urs; id_uses_rt = i.urt; id_dst = i.dst;
    id_rd1 = i.a; id_rd2 = i.b; id_imm = i.imm; id_alu_op = i.op;
    id_reg_we = i.we; id_mem_rd = i.mr; id_mem_wr = i.mw;
  endtask

  task automatic chk_ex(input string tag, input ins_t e, input logic [1:0] elu,
                        input logic [1:0] efl);
    chk({tag, ".valid"}, 64'(ex_valid), 64'(e.v));
    chk({tag, ".pc"},    64'(ex_pc),    64'(e.pc));
    chk({tag, ".a"},     64'(ex_a),     64'(e.a));
    chk({tag, ".b"},     64'(ex_b),     64'(e.b));
    chk({tag, ".imm"},   64'(ex_imm),   64'(e.imm));
    chk({tag, ".regs"},  64'({ex_rs, ex_rt, ex_dst}), 64'({e.rs, e.rt, e.dst}));
    chk({tag, ".op"},    64'(ex_alu_op), 64'(e.op));
    chk({tag, ".ctl"},   64'({ex_reg_we, ex_mem_rd, ex_mem_wr}), 64'({e.we, e.mr, e.mw}));
    chk({tag, ".lu_cnt"}, 64'(lu_cnt), 64'(elu));
    chk({tag, ".fl_cnt"}, 64'(fl_cnt), 64'(efl));
  endtask

  initial begin
    ins_t z, i0, i1, i2, lw8, use8, use8b, lw0, use0, lw8c, sw, lw8d, fuse;
    ins_t i2c, i30, inv, inv_o, hold, i40;
    logic [1:0] sat_exp [5];

    z     = mk(0, 32'h0,  0, 0, 0, 0, 0,  32'h0,  32'h0,  32'h0, 0, 0, 0, 0);
    i0    = mk(1, 32'h0,  1, 2, 1, 1, 3,  32'd11, 32'd22, 32'd5, 2, 1, 0, 0);
    i1    = mk(1, 32'h4,  3, 4, 1, 1, 5,  32'd33, 32'd44, 32'd6, 2, 1, 0, 0);
    i2    = mk(1, 32'h8,  5, 6, 1, 1, 7,  32'd55, 32'd66, 32'd7, 2, 1, 0, 0);
    lw8   = mk(1, 32'hC,  1, 0, 1, 0, 8,  32'd100, 32'h0, 32'd4, 0, 1, 1, 0);
    use8  = mk(1, 32'h10, 8, 2, 1, 1, 9,  32'hAA,   32'd22, 32'h0, 2, 1, 0, 0);
    use8b = mk(1, 32'h10, 8, 2, 1, 1, 9,  32'h1234, 32'd22, 32'h0, 2, 1, 0, 0);
    lw0   = mk(1, 32'h14, 1, 0, 1, 0, 0,  32'd7,  32'h0,  32'h0, 0, 1, 1, 0);
    use0  = mk(1, 32'h18, 0, 0, 1, 1, 10, 32'd1,  32'd2,  32'h0, 2, 1, 0, 0);
    lw8c  = mk(1, 32'h1C, 2, 0, 1, 0, 8,  32'd3,  32'h0,  32'h0, 0, 1, 1, 0);
    sw    = mk(1, 32'h20, 1, 8, 1, 0, 0,  32'd4,  32'd5,  32'd8, 0, 0, 0, 1);
    lw8d  = mk(1, 32'h24, 1, 0, 1, 0, 8,  32'h0,  32'h0,  32'h0, 0, 1, 1, 0);
    fuse  = mk(1, 32'h28, 8, 0, 1, 0, 11, 32'd6,  32'h0,  32'h0, 2, 1, 0, 0);
    i2c   = mk(1, 32'h2C, 1, 2, 1, 1, 12, 32'h77, 32'h88, 32'h99, 3, 1, 0, 0);
    i30   = mk(1, 32'h30, 1, 2, 1, 1, 13, 32'd1,  32'd1,  32'd1, 1, 1, 0, 0);
    inv   = mk(0, 32'h50, 1, 2, 1, 1, 14, 32'd9,  32'd8,  32'd7, 5, 1, 1, 1);
    inv_o = mk(0, 32'h50, 1, 2, 1, 1, 14, 32'd9,  32'd8,  32'd7, 5, 0, 0, 0);
    hold  = mk(1, 32'h10, 3, 4, 1, 1, 5,  32'hDEADBEEF, 32'd2, 32'd3, 1, 1, 0, 0);
    i40   = mk(1, 32'h40, 5, 6, 1, 1, 7,  32'd1,  32'd2,  32'd3, 4, 1, 0, 0);

    //  stall_ex flush  in     id_stall expected-ex  lu    fl
    add(1'b0, 1'b0, i0,    1'b0, i0,    2'd0, 2'd0);
    add(1'b0, 1'b0, i1,    1'b0, i1,    2'd0, 2'd0);
    add(1'b0, 1'b0, i2,    1'b0, i2,    2'd0, 2'd0);
    add(1'b0, 1'b0, lw8,   1'b0, lw8,   2'd0, 2'd0);
    add(1'b0, 1'b0, use8,  1'b1, z,     2'd1, 2'd0);
    add(1'b0, 1'b0, use8b, 1'b0, use8b, 2'd1, 2'd0);
    add(1'b0, 1'b0, lw0,   1'b0, lw0,   2'd1, 2'd0);
    add(1'b0, 1'b0, use0,  1'b0, use0,  2'd1, 2'd0);
    add(1'b0, 1'b0, lw8c,  1'b0, lw8c,  2'd1, 2'd0);
    add(1'b0, 1'b0, sw,    1'b0, sw,    2'd1, 2'd0);
    add(1'b0, 1'b0, lw8d,  1'b0, lw8d,  2'd1, 2'd0);
    add(1'b0, 1'b1, fuse,  1'b1, z,     2'd1, 2'd1);
    add(1'b0, 1'b0, i2c,   1'b0, i2c,   2'd1, 2'd1);
    add(1'b1, 1'b1, i30,   1'b1, i2c,   2'd1, 2'd1);
    add(1'b0, 1'b0, inv,   1'b0, inv_o, 2'd1, 2'd1);
    add(1'b0, 1'b0, hold,  1'b0, hold,  2'd1, 2'd1);
    add(1'b1, 1'b0, i40,   1'b1, hold,  2'd1, 2'd1);
    add(1'b1, 1'b0, i40,   1'b1, hold,  2'd1, 2'd1);
    add(1'b1, 1'b0, i40,   1'b1, hold,  2'd1, 2'd1);

    // Reset state, with stall_ex both high and low
    rst = 1'b1; stall_ex = 1'b1; flush = 1'b0; drive(z);
    #2;
    chk_ex("reset", z, 2'd0, 2'd0);
    chk("reset.id_stall_hi", 64'(id_stall), 64'd1);
    stall_ex = 1'b0;
    #1;
    chk("reset.id_stall_lo", 64'(id_stall), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < vecs.size(); n++) begin
      stall_ex = vecs[n].sx; flush = vecs[n].fl; drive(vecs[n].in);
      #1;
      chk($sformatf("v%0d.id_stall", n), 64'(id_stall), 64'(vecs[n].e_st));
      @(posedge clk);
      #1;
      chk_ex($sformatf("v%0d", n), vecs[n].out, vecs[n].e_lu, vecs[n].e_fl);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a stall clears before the next edge
    #2;
    rst = 1'b1;
    #1;
    chk_ex("midrst", z, 2'd0, 2'd0);
    chk("midrst.id_stall", 64'(id_stall), 64'd1);
    @(negedge clk);
    rst = 1'b0; stall_ex = 1'b0;

    // Saturation of the 2-bit flush counter
    sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3;
    sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;
    flush = 1'b1; drive(i0);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("sat%0d.fl_cnt", k), 64'(fl_cnt), 64'(sat_exp[k]));
      chk($sformatf("sat%0d.valid", k), 64'(ex_valid), 64'd0);
      chk($sformatf("sat%0d.lu_cnt", k), 64'(lu_cnt), 64'd0);
    end
    flush = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
